// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: active-low digit
// patterns (dp in bit 7, segments g..a in bits 6..0) and the scan state type.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK   = 8'hFF;

    localparam logic [7:0] SEG_DIGIT_0 = 8'hC0;
    localparam logic [7:0] SEG_DIGIT_1 = 8'hF9;
    localparam logic [7:0] SEG_DIGIT_2 = 8'hA4;
    localparam logic [7:0] SEG_DIGIT_3 = 8'hB0;
    localparam logic [7:0] SEG_DIGIT_4 = 8'h99;
    localparam logic [7:0] SEG_DIGIT_5 = 8'h92;
    localparam logic [7:0] SEG_DIGIT_6 = 8'h82;
    localparam logic [7:0] SEG_DIGIT_7 = 8'hF8;
    localparam logic [7:0] SEG_DIGIT_8 = 8'h80;
    localparam logic [7:0] SEG_DIGIT_9 = 8'h90;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Map a BCD value to its pattern; anything above 9 renders dark.
    function automatic logic [7:0] seg_digit(input logic [3:0] value);
        logic [7:0] pattern;
        case (value)
            4'd0:    pattern = SEG_DIGIT_0;
            4'd1:    pattern = SEG_DIGIT_1;
            4'd2:    pattern = SEG_DIGIT_2;
            4'd3:    pattern = SEG_DIGIT_3;
            4'd4:    pattern = SEG_DIGIT_4;
            4'd5:    pattern = SEG_DIGIT_5;
            4'd6:    pattern = SEG_DIGIT_6;
            4'd7:    pattern = SEG_DIGIT_7;
            4'd8:    pattern = SEG_DIGIT_8;
            4'd9:    pattern = SEG_DIGIT_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot prescaler and digit counter for the scan multiplexer.
// cnt runs 0..SCAN_DIV-1 within a slot; digit index steps at each slot end
// and wraps after the last digit. o_in_blank looks ahead: it describes the
// cycle that follows the next clock edge, so the owner can register outputs
// that line up with the counter values.
module seg7_slot_timer #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_advance,
    input  logic                          i_clear,
    output logic                          o_in_blank,
    output logic                          o_slot_end,
    output logic                          o_frame_wrap,
    output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;

    assign o_slot_end   = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign o_frame_wrap = o_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign o_in_blank   = (w_cnt_next < CNT_W'(BLANK_CYCLES));
    assign o_digit_idx  = r_idx;

    // Next count: clear wins, otherwise step the prescaler and roll the digit at slot end.
    always_comb begin
        w_cnt_next = r_cnt;
        w_idx_next = r_idx;
        if (i_clear) begin
            w_cnt_next = '0;
            w_idx_next = '0;
        end else if (i_advance) begin
            if (o_slot_end) begin
                w_cnt_next = '0;
                w_idx_next = o_frame_wrap ? '0 : r_idx + IDX_W'(1);
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            r_idx <= w_idx_next;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver. Scans NUM_DIGITS active-low patterns
// onto one segment bus with a blanking gap at the start of each digit slot.
// New patterns are staged on upd and promoted to the displayed (shadow) set
// only at a frame boundary, so a frame never shows a mix of old and new data.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          upd,
    input  logic [8*NUM_DIGITS-1:0]       seg_in,
    output logic [7:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    scan_state_t            r_state;
    scan_state_t            w_state_next;
    logic                   w_advance;
    logic                   w_clear;
    logic                   w_in_blank;
    logic                   w_slot_end;
    logic                   w_frame_wrap;
    logic                   w_boundary;
    logic [IDX_W-1:0]       w_idx;
    logic [NUM_DIGITS-1:0]  w_an_onehot;

    logic [7:0]             w_seg_in  [NUM_DIGITS];
    logic [7:0]             r_staging [NUM_DIGITS];
    logic [7:0]             r_shadow  [NUM_DIGITS];
    logic                   r_pending;

    logic [7:0]             r_seg_out;
    logic [NUM_DIGITS-1:0]  r_an;
    logic                   r_frame_tick;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
        assign w_seg_in[gi] = seg_in[8*gi +: 8];
    end

    // The counters only move while scanning; dropping enable parks them at zero.
    assign w_advance = enable && (r_state != ST_IDLE);
    assign w_clear   = !enable;

    seg7_slot_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_advance    (w_advance),
        .i_clear      (w_clear),
        .o_in_blank   (w_in_blank),
        .o_slot_end   (w_slot_end),
        .o_frame_wrap (w_frame_wrap),
        .o_digit_idx  (w_idx)
    );

    // Next-state logic; w_boundary marks the edge that enters cycle 0 of a frame.
    always_comb begin
        w_state_next = r_state;
        w_boundary   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next = ST_BLANK;
                    w_boundary   = 1'b1;
                end
            end
            ST_BLANK: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (!w_in_blank) begin
                    w_state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_slot_end) begin
                    w_state_next = ST_BLANK;
                    w_boundary   = w_frame_wrap;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Staging/shadow buffers: upd at the boundary edge bypasses staging so it is not lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_staging[i] <= SEG_BLANK;
                r_shadow[i]  <= SEG_BLANK;
            end
        end else begin
            if (upd) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_staging[i] <= w_seg_in[i];
                end
            end
            if (w_boundary) begin
                r_pending <= 1'b0;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (upd) begin
                        r_shadow[i] <= w_seg_in[i];
                    end else if (r_pending) begin
                        r_shadow[i] <= r_staging[i];
                    end
                end
            end else if (upd) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_an_onehot = NUM_DIGITS'(1) << w_idx;

    // Output registers follow the state being entered. The digit index and shadow
    // never change on an edge that enters SHOW, so their current values are used.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_seg_out    <= SEG_BLANK;
            r_an         <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_boundary;
            if (w_state_next == ST_SHOW) begin
                r_an      <= ~w_an_onehot;
                r_seg_out <= r_shadow[w_idx];
            end else begin
                r_an      <= '1;
                r_seg_out <= SEG_BLANK;
            end
        end
    end

    assign seg_out    = r_seg_out;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;
    assign digit_idx  = w_idx;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Testbench for seg7_scan_mux with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
// A frame-position model (cycle k within the frame) predicts every output on
// every cycle; directed checks with literal values pin the key moments.
module tb_seg7_scan_mux;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SD;

    logic            clk;
    logic            rst;
    logic            enable;
    logic            upd;
    logic [8*ND-1:0] seg_in;
    logic [7:0]      seg_out;
    logic [ND-1:0]   an;
    logic [1:0]      digit_idx;
    logic            frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_mux #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .upd        (upd),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_pins(input string tag, input logic [7:0] eseg, input logic [3:0] ean);
        chk({tag, " seg_out"}, 32'(seg_out), 32'(eseg));
        chk({tag, " an"}, 32'(an), 32'(ean));
    endtask

    // ---------------- model: position within frame ----------------
    bit         m_valid = 1'b0;
    bit         m_run   = 1'b0;
    bit         m_start;
    int         m_k     = 0;
    bit         m_pending;
    logic [7:0] m_shadow  [ND];
    logic [7:0] m_staging [ND];

    initial begin
        forever begin
            @(posedge clk);
            m_start = 1'b0;
            if (!rst) begin
                m_valid   = 1'b1;
                m_run     = 1'b0;
                m_k       = 0;
                m_pending = 1'b0;
                for (int i = 0; i < ND; i++) begin
                    m_shadow[i]  = 8'hFF;
                    m_staging[i] = 8'hFF;
                end
            end else begin
                if (!enable) begin
                    m_run = 1'b0;
                    m_k   = 0;
                end else if (!m_run) begin
                    m_run   = 1'b1;
                    m_k     = 0;
                    m_start = 1'b1;
                end else begin
                    m_k     = (m_k + 1) % FRAME;
                    m_start = (m_k == 0);
                end
                if (m_start) begin
                    for (int i = 0; i < ND; i++) begin
                        if (upd) m_shadow[i] = seg_in[8*i +: 8];
                        else if (m_pending) m_shadow[i] = m_staging[i];
                    end
                    m_pending = 1'b0;
                end else if (upd) begin
                    for (int i = 0; i < ND; i++) m_staging[i] = seg_in[8*i +: 8];
                    m_pending = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    int         c_d;
    int         c_off;
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic [1:0] e_idx;
    logic       e_tick;

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e_seg  = 8'hFF;
                e_an   = 4'hF;
                e_idx  = 2'd0;
                e_tick = 1'b0;
                if (m_run) begin
                    c_d    = m_k / SD;
                    c_off  = m_k % SD;
                    e_idx  = 2'(c_d);
                    e_tick = (m_k == 0);
                    if (c_off >= BC) begin
                        e_an  = ~(4'b0001 << c_d);
                        e_seg = m_shadow[c_d];
                    end
                end
                chk($sformatf("model k=%0d seg_out", m_k), 32'(seg_out), 32'(e_seg));
                chk($sformatf("model k=%0d an", m_k), 32'(an), 32'(e_an));
                chk($sformatf("model k=%0d digit_idx", m_k), 32'(digit_idx), 32'(e_idx));
                chk($sformatf("model k=%0d frame_tick", m_k), 32'(frame_tick), 32'(e_tick));
            end
        end
    end

    // Advance to the negedge of frame cycle `target`, bounded.
    task automatic wait_k(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_run && m_k == target) && n < 200);
        if (!(m_run && m_k == target)) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_k: reached k=%0d run=%0d, required k=%0d", m_k, m_run, target);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst    = 1'b0;
        enable = 1'b1;
        upd    = 1'b0;
        seg_in = $urandom;

        // Reset held with enable high and random data.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_pins($sformatf("reset%0d", i), 8'hFF, 4'hF);
            chk($sformatf("reset%0d digit_idx", i), 32'(digit_idx), 32'h0);
            chk($sformatf("reset%0d frame_tick", i), 32'(frame_tick), 32'h0);
            seg_in = $urandom;
            upd    = 1'b1;
        end

        // Load data in IDLE, then start scanning.
        rst    = 1'b1;
        enable = 1'b0;
        seg_in = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
        upd    = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        chk_pins("idle", 8'hFF, 4'hF);
        @(negedge clk);
        enable = 1'b1;

        // Frame 1: basic scan; mid-frame update of digit0 at k=12.
        wait_k(0);
        chk("f1 k0 frame_tick", 32'(frame_tick), 32'h1);
        chk_pins("f1 k0", 8'hFF, 4'hF);
        wait_k(1);
        chk_pins("f1 k1", 8'hFF, 4'hF);
        wait_k(2);
        chk_pins("f1 k2", 8'hC0, 4'hE);
        wait_k(7);
        chk_pins("f1 k7", 8'hC0, 4'hE);
        wait_k(10);
        chk_pins("f1 k10", 8'hF9, 4'hD);
        wait_k(12);
        seg_in = {8'hB0, 8'hA4, 8'hF9, 8'h90};
        upd    = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        wait_k(18);
        chk_pins("f1 k18", 8'hA4, 4'hB);
        wait_k(26);
        chk_pins("f1 k26", 8'hB0, 4'h7);
        wait_k(31);
        chk_pins("f1 k31", 8'hB0, 4'h7);

        // Frame 2: new digit0 shows; then 99 staged, overwritten by 92 on the boundary cycle.
        wait_k(0);
        chk("f2 k0 frame_tick", 32'(frame_tick), 32'h1);
        wait_k(2);
        chk_pins("f2 k2", 8'h90, 4'hE);
        wait_k(10);
        chk_pins("f2 k10", 8'hF9, 4'hD);
        wait_k(20);
        seg_in[7:0] = 8'h99;
        upd         = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        wait_k(31);
        seg_in[7:0] = 8'h92;
        upd         = 1'b1;

        // Frame 3: 92 shows; pending 82 staged, then enable dropped at k=20.
        wait_k(0);
        upd = 1'b0;
        wait_k(2);
        chk_pins("f3 k2", 8'h92, 4'hE);
        wait_k(15);
        seg_in[7:0] = 8'h82;
        upd         = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        wait_k(20);
        chk_pins("f3 k20", 8'hA4, 4'hB);
        enable = 1'b0;
        @(negedge clk);
        chk_pins("drop", 8'hFF, 4'hF);
        chk("drop digit_idx", 32'(digit_idx), 32'h0);
        repeat (4) @(negedge clk);
        enable = 1'b1;
        wait_k(0);
        chk("reen k0 frame_tick", 32'(frame_tick), 32'h1);
        wait_k(2);
        chk_pins("reen k2", 8'h82, 4'hE);

        // Reset mid-SHOW with a pending update.
        wait_k(10);
        seg_in[7:0] = 8'hF8;
        upd         = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        wait_k(13);
        chk_pins("pre-rst k13", 8'hF9, 4'hD);
        rst = 1'b0;
        @(negedge clk);
        chk_pins("midrst", 8'hFF, 4'hF);
        chk("midrst digit_idx", 32'(digit_idx), 32'h0);
        chk("midrst frame_tick", 32'(frame_tick), 32'h0);
        rst = 1'b1;
        wait_k(0);
        chk("post-rst k0 frame_tick", 32'(frame_tick), 32'h1);
        wait_k(2);
        chk_pins("post-rst k2", 8'hFF, 4'hE);
        wait_k(26);
        chk_pins("post-rst k26", 8'hFF, 4'h7);
        wait_k(2);
        chk_pins("post-rst next k2", 8'hFF, 4'hE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
